// File: rtl/pipe_mw_skid.sv
// MEM->WB pipeline register with a one-entry skid buffer.
// The head entry drives the outputs, and its writeback data is selected and stored when the entry loads.
module pipe_mw_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RN_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_wreg,
  input  logic              i_m2reg,
  input  logic [DATA_W-1:0] i_mo,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [RN_W-1:0]   i_rn,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_wreg,
  output logic              o_m2reg,
  output logic [DATA_W-1:0] o_mo,
  output logic [DATA_W-1:0] o_alu,
  output logic [RN_W-1:0]   o_rn,
  output logic [DATA_W-1:0] o_wdata,
  output logic [1:0]        o_occ
);

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic [DATA_W-1:0] mo;
    logic [DATA_W-1:0] alu;
    logic [RN_W-1:0]   rn;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MAIN_HOLD = 2'd0,
    MAIN_IN   = 2'd1,
    MAIN_SKID = 2'd2,
    MAIN_CLRW = 2'd3
  } main_sel_t;

  state_t    state_q, state_d;
  main_sel_t main_sel;
  logic      skid_load;
  logic      accept, rel;
  entry_t    main_q, skid_q, in_e;

  // Ready depends only on state and reset, never on the downstream ready.
  assign o_ready = ~rst & (state_q != TWO);
  assign o_valid = (state_q != EMPTY);
  assign o_occ   = state_q;

  assign accept = i_valid & o_ready;
  assign rel    = o_valid & i_ready;

  // Incoming entry, with the writeback mux resolved before storage.
  always_comb begin
    in_e.wreg  = i_wreg;
    in_e.m2reg = i_m2reg;
    in_e.mo    = i_mo;
    in_e.alu   = i_alu;
    in_e.rn    = i_rn;
    in_e.wdata = i_m2reg ? i_mo : i_alu;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state and datapath steering. Flush overrides any accept or release.
  always_comb begin
    state_d   = state_q;
    main_sel  = MAIN_HOLD;
    skid_load = 1'b0;
    if (i_flush) begin
      state_d  = EMPTY;
      main_sel = MAIN_CLRW;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d  = ONE;
            main_sel = MAIN_IN;
          end
        end
        ONE: begin
          if (accept && !rel) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (accept && rel) begin
            main_sel = MAIN_IN;
          end else if (rel) begin
            state_d  = EMPTY;
            main_sel = MAIN_CLRW;
          end
        end
        TWO: begin
          if (rel) begin
            state_d  = ONE;
            main_sel = MAIN_SKID;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_sel = MAIN_CLRW;
        end
      endcase
    end
  end

  // Write enable is cleared whenever the stage goes empty so bubbles never write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      unique case (main_sel)
        MAIN_IN:   main_q      <= in_e;
        MAIN_SKID: main_q      <= skid_q;
        MAIN_CLRW: main_q.wreg <= 1'b0;
        default:   main_q      <= main_q;
      endcase
      if (skid_load) skid_q <= in_e;
    end
  end

  assign o_wreg  = main_q.wreg;
  assign o_m2reg = main_q.m2reg;
  assign o_mo    = main_q.mo;
  assign o_alu   = main_q.alu;
  assign o_rn    = main_q.rn;
  assign o_wdata = main_q.wdata;

endmodule

// File: tb/tb_pipe_mw_skid.sv
// Scoreboard bench for pipe_mw_skid: expected entries are queued as they are accepted
// and checked in order as they reach the head.
module tb_pipe_mw_skid;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RN_W   = 5;

  typedef struct {
    logic              wreg;
    logic              m2reg;
    logic [DATA_W-1:0] mo;
    logic [DATA_W-1:0] alu;
    logic [RN_W-1:0]   rn;
  } ent_t;

  logic              clk, rst;
  logic              i_valid, o_ready, i_wreg, i_m2reg, i_flush, o_valid, i_ready;
  logic [DATA_W-1:0] i_mo, i_alu, o_mo, o_alu, o_wdata;
  logic [RN_W-1:0]   i_rn, o_rn;
  logic              o_wreg, o_m2reg;
  logic [1:0]        o_occ;

  int checks = 0;
  int errors = 0;
  ent_t exp_q[$];

  pipe_mw_skid #(.DATA_W(DATA_W), .RN_W(RN_W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_wreg(i_wreg), .i_m2reg(i_m2reg), .i_mo(i_mo), .i_alu(i_alu), .i_rn(i_rn),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_wreg(o_wreg), .o_m2reg(o_m2reg), .o_mo(o_mo), .o_alu(o_alu), .o_rn(o_rn),
    .o_wdata(o_wdata), .o_occ(o_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare the DUT against the head of the scoreboard.
  task automatic check_outputs(input string tag);
    int n;
    ent_t e;
    logic [DATA_W-1:0] wd;
    n = exp_q.size();
    check_eq({tag, ".occ"},   64'(o_occ),   64'(n));
    check_eq({tag, ".valid"}, 64'(o_valid), 64'(n != 0));
    check_eq({tag, ".ready"}, 64'(o_ready), 64'(n < 2));
    if (n != 0) begin
      e  = exp_q[0];
      wd = e.m2reg ? e.mo : e.alu;
      check_eq({tag, ".rn"},    64'(o_rn),    64'(e.rn));
      check_eq({tag, ".wdata"}, 64'(o_wdata), 64'(wd));
      check_eq({tag, ".wreg"},  64'(o_wreg),  64'(e.wreg));
      check_eq({tag, ".m2reg"}, 64'(o_m2reg), 64'(e.m2reg));
      check_eq({tag, ".mo"},    64'(o_mo),    64'(e.mo));
      check_eq({tag, ".alu"},   64'(o_alu),   64'(e.alu));
    end else begin
      check_eq({tag, ".wreg_bubble"}, 64'(o_wreg), 64'd0);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then check after the edge.
  task automatic cycle(input string tag, input logic v, input logic w, input logic m2,
                       input logic [DATA_W-1:0] mo, input logic [DATA_W-1:0] alu,
                       input logic [RN_W-1:0] rn, input logic rdy, input logic fl);
    ent_t e;
    logic acc, rl;
    i_valid = v; i_wreg = w; i_m2reg = m2; i_mo = mo; i_alu = alu; i_rn = rn;
    i_ready = rdy; i_flush = fl;
    acc = v && (exp_q.size() < 2);
    rl  = rdy && (exp_q.size() != 0);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rl) void'(exp_q.pop_front());
      if (acc) begin
        e.wreg = w; e.m2reg = m2; e.mo = mo; e.alu = alu; e.rn = rn;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input logic rdy);
    cycle(tag, 1'b0, 1'b0, 1'b0, '0, '0, '0, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 0; i_wreg = 0; i_m2reg = 0; i_mo = '0; i_alu = '0; i_rn = '0;
    i_ready = 0; i_flush = 0;

    // Reset values and reset release between edges.
    #12;
    check_eq("rst.occ",   64'(o_occ),   64'd0);
    check_eq("rst.valid", 64'(o_valid), 64'd0);
    check_eq("rst.ready", 64'(o_ready), 64'd0);
    check_eq("rst.wreg",  64'(o_wreg),  64'd0);
    check_eq("rst.rn",    64'(o_rn),    64'd0);
    check_eq("rst.wdata", 64'(o_wdata), 64'd0);
    check_eq("rst.mo",    64'(o_mo),    64'd0);
    check_eq("rst.alu",   64'(o_alu),   64'd0);
    rst = 1'b0;
    #1;
    check_eq("rstrel.ready", 64'(o_ready), 64'd1);
    check_eq("rstrel.occ",   64'(o_occ),   64'd0);
    @(posedge clk);
    #1;
    check_outputs("post_rst");

    // Streaming with both sides always ready.
    for (int i = 1; i <= 8; i++)
      cycle("stream", 1'b1, 1'b1, 1'b0, 32'hFFFF0000 + 32'(i), 32'(i * 16), RN_W'(i), 1'b1, 1'b0);
    idle("stream_drain", 1'b1);
    idle("stream_empty", 1'b1);

    // Backpressure: fill both slots and hold.
    cycle("bp3", 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h00000033, 5'd3, 1'b0, 1'b0);
    cycle("bp4", 1'b1, 1'b1, 1'b0, 32'h12345678, 32'h00000044, 5'd4, 1'b0, 1'b0);
    cycle("bp_full", 1'b1, 1'b1, 1'b0, 32'h0BADF00D, 32'h00000055, 5'd5, 1'b0, 1'b0);
    idle("bp_hold", 1'b0);
    idle("bp_rel1", 1'b1);
    idle("bp_rel2", 1'b1);

    // Simultaneous accept and release while holding one entry.
    cycle("sim_fill", 1'b1, 1'b1, 1'b0, 32'h1, 32'hAAAA0001, 5'd10, 1'b0, 1'b0);
    cycle("sim_swap", 1'b1, 1'b0, 1'b1, 32'hBBBB0002, 32'h2, 5'd11, 1'b1, 1'b0);
    idle("sim_drain", 1'b1);

    // Flush while full with a valid input present.
    cycle("fl_a", 1'b1, 1'b1, 1'b0, 32'h0, 32'h00000101, 5'd20, 1'b0, 1'b0);
    cycle("fl_b", 1'b1, 1'b1, 1'b0, 32'h0, 32'h00000202, 5'd21, 1'b0, 1'b0);
    cycle("fl_go", 1'b1, 1'b1, 1'b0, 32'h0, 32'h00000303, 5'd22, 1'b1, 1'b1);
    cycle("fl_after", 1'b1, 1'b1, 1'b0, 32'h0, 32'h00000404, 5'd23, 1'b1, 1'b0);
    idle("fl_drain", 1'b1);

    // Bubbles with write enable high must never show a write.
    for (int i = 0; i < 3; i++)
      cycle("bubble", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0);

    // Asynchronous reset while full.
    cycle("ar_a", 1'b1, 1'b1, 1'b0, 32'h0, 32'h00000111, 5'd1, 1'b0, 1'b0);
    cycle("ar_b", 1'b1, 1'b1, 1'b0, 32'h0, 32'h00000222, 5'd2, 1'b0, 1'b0);
    i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst.occ",   64'(o_occ),   64'd0);
    check_eq("arst.valid", 64'(o_valid), 64'd0);
    check_eq("arst.ready", 64'(o_ready), 64'd0);
    check_eq("arst.wreg",  64'(o_wreg),  64'd0);
    check_eq("arst.wdata", 64'(o_wdata), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    #1;
    check_eq("arst_rel.ready", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1;
    check_outputs("arst_post");

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 300; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), $urandom, $urandom,
            RN_W'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < 3; i++) idle("rand_drain", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_mw_skid.md
PIPE_MW_SKID -- requirements
Module: pipe_mw_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of memory-out and ALU result fields.
REQ-002 SHALL have parameter RN_W, default 5, width of destination register number.
REQ-003 SHALL have one clock; reset is asynchronous and active-high, ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 i_valid  input  1  upstream (MEM) entry valid.
REQ-007 o_ready  output  1  this block can accept an upstream entry.
REQ-008 i_wreg, i_m2reg  input  1 each  register-write enable; select memory data for writeback.
REQ-009 i_mo, i_alu  input  DATA_W each  memory read data; ALU result.
REQ-010 i_rn  input  RN_W  destination register number.
REQ-011 i_flush  input  1  synchronous discard of all held entries.
REQ-012 o_valid  output  1  downstream (WB) entry valid.
REQ-013 i_ready  input  1  downstream accepts current entry.
REQ-014 o_wreg, o_m2reg, o_mo, o_alu, o_rn  output  1/1/DATA_W/DATA_W/RN_W  head entry fields.
REQ-015 o_wdata  output  DATA_W  head writeback data, registered.
REQ-016 o_occ  output  2  number of entries held (0..2).

Function
REQ-017 SHALL hold up to two entries: main (head, drives outputs) and skid; state EMPTY/ONE/TWO, o_occ = 0/1/2.
REQ-018 Accept = i_valid & o_ready at rising edge; release = o_valid & i_ready at rising edge.
REQ-019 o_ready SHALL be 1 iff state != TWO and rst low; no combinational path from i_ready to o_ready.
REQ-020 o_valid SHALL be 1 iff state != EMPTY.
REQ-021 EMPTY: accept -> main <= input, ONE.
REQ-022 ONE: accept & !release -> skid <= input, TWO; accept & release -> main <= input, ONE; release only -> EMPTY; neither -> hold.
REQ-023 TWO: release -> main <= skid, ONE; else hold; no accept possible.
REQ-024 Latency: accepted entry SHALL appear at outputs the cycle after acceptance when main is free or released in that cycle.
REQ-025 Order SHALL be strictly FIFO; no entry dropped or duplicated except by flush.
REQ-026 o_wdata SHALL equal (m2reg ? mo : alu) of the head entry, computed on load and stored, not after the output register.
REQ-027 o_wreg SHALL be 0 whenever o_valid is 0, so bubbles never write the register file.
REQ-028 Data outputs with o_valid = 0 SHALL hold last values (don't-care for checking), except o_wreg per REQ-027.
REQ-029 i_flush high at an edge SHALL force EMPTY; any accept/release in that cycle ignored, input dropped; o_ready is 1 next cycle.
REQ-030 Holding (no release) SHALL keep all head outputs stable while o_valid = 1.
REQ-031 Throughput SHALL be one entry per cycle with i_valid and i_ready continuously high.

Reset
REQ-032 rst high SHALL asynchronously force state EMPTY, o_occ = 0, o_valid = 0, o_ready = 0, and o_wreg, o_m2reg, o_mo, o_alu, o_rn, o_wdata, skid contents = 0.
REQ-033 After rst deasserts, o_ready SHALL be 1 with no clock edge required; first accept possible at the next edge.
REQ-034 rst asserted mid-operation (state TWO) SHALL discard both entries immediately without waiting for clk.

Verification
REQ-035 Reset: rst=1 between edges -> all outputs 0 same time step; release -> o_ready=1, o_occ=0.
REQ-036 Streaming: i_valid=i_ready=1, entries rn=1..8, alu=rn*16, m2reg=0 -> o_rn 1..8 on consecutive cycles 1 cycle late, o_wdata=0x10..0x80, o_occ=1 throughout.
REQ-037 Backpressure: i_ready=0, send rn=3 (m2reg=1, mo=0xDEADBEEF) then rn=4 -> o_occ=2, o_ready=0, outputs stay rn=3/o_wdata=0xDEADBEEF; i_ready=1 -> rn=3 then rn=4, o_ready=1 after first release.
REQ-038 Simultaneous: state ONE, accept and release same edge -> o_occ stays 1, head becomes new entry.
REQ-039 Flush: state TWO, i_flush=1 with i_valid=1 -> next cycle o_occ=0, o_valid=0, o_wreg=0, flushed-cycle input never appears.
REQ-040 Bubble: i_valid=0 with i_wreg=1 for 3 cycles from EMPTY -> o_wreg=0, o_valid=0 throughout.
